// File: rtl/dmem_store_buffer_pkg.sv
// Shared data-memory store definitions: byte-enable type, enable constants, store entry layout.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package dmem_store_buffer_pkg;

  // One enable bit per byte lane of a 32-bit data word.
  typedef logic [3:0] dmem_we_t;

  localparam dmem_we_t WE_NONE = 4'b0000;
  localparam dmem_we_t WE_WORD = 4'b1111;

  // Byte address width the entry layout is sized for. Designs using a
  // narrower address zero-extend the word address into this field.
  localparam int DMEM_AW   = 32;
  localparam int DMEM_WA_W = DMEM_AW - 2;

  typedef logic [DMEM_WA_W-1:0] dmem_waddr_t;

  // One queued store: word address, lane-aligned data and byte enables.
  typedef struct packed {
    dmem_waddr_t waddr;
    logic [31:0] data;
    dmem_we_t    we;
  } sb_entry_t;

  // Expand per-lane enables into a 32-bit bit mask (lane i -> bits 8i+7:8i).
  function automatic logic [31:0] we_to_mask(input dmem_we_t we);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{we[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/sb_byte_merge.sv
// Per-lane merge of a new partial store into an existing store word.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the merged result is written.
module sb_byte_merge
  import dmem_store_buffer_pkg::*;
(
  input  logic [31:0] old_data,
  input  dmem_we_t    old_we,
  input  logic [31:0] new_data,
  input  dmem_we_t    new_we,
  output logic [31:0] merged_data,
  output dmem_we_t    merged_we
);

  logic [31:0] lane_mask;

  // Lanes enabled by the new store take its byte; all other lanes keep the old byte and enable.
  always_comb begin
    lane_mask   = we_to_mask(new_we);
    merged_data = (old_data & ~lane_mask) | (new_data & lane_mask);
    merged_we   = old_we | new_we;
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer: queues lane-aligned stores in order, merges same-word stores into the newest entry, drains to data memory.
// Latency: an accepted store is presented on mem_* from the next cycle; mem_req && mem_ack retires the head at that edge (zero-latency ack allowed).
// Backpressure: st_ready is low while all DEPTH entries are occupied (a same-cycle pop does not free a slot); the head stays stable until acked.
module dmem_store_buffer
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,  // power of two, >= 2
  parameter int AW    = 32  // byte address width, <= DMEM_AW
) (
  input  logic          clk,
  input  logic          rst,
  // store lane from the MEM-stage aligner
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic [3:0]    st_we,
  // load hazard probe
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hazard,
  // data memory write port
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_we,
  input  logic          mem_ack,
  output logic          sb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] MERGE_MIN_CNT = CW'(2);

  sb_entry_t      entries [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [PW-1:0]  tail_m1;
  logic [CW-1:0]  count;

  dmem_waddr_t    st_word;
  dmem_waddr_t    ld_word;
  sb_entry_t      head_ent;
  sb_entry_t      newest_ent;

  logic           st_take;
  logic           coalesce;
  logic           push;
  logic           pop;

  logic [31:0]    merged_data;
  dmem_we_t       merged_we;

  logic [DEPTH-1:0] ent_live;
  logic [DEPTH-1:0] ld_match;

  // Byte-offset bits are irrelevant at word granularity.
  logic           unused_offsets;
  assign unused_offsets = ^{st_addr[1:0], ld_addr[1:0]};

  assign st_word    = dmem_waddr_t'(st_addr[AW-1:2]);
  assign ld_word    = dmem_waddr_t'(ld_addr[AW-1:2]);
  assign tail_m1    = tail - PW'(1);
  assign head_ent   = entries[head];
  assign newest_ent = entries[tail_m1];

  // Acceptance looks only at the registered count so a full buffer never
  // depends on the memory ack path in the same cycle.
  assign st_ready = (count != FULL_CNT);
  assign sb_empty = (count == '0);
  assign mem_req  = !sb_empty;

  // A store with no enabled lanes is accepted but changes nothing.
  assign st_take = st_valid && st_ready && (st_we != WE_NONE);

  // Merge only into the newest entry when it is not the head: with two or
  // more entries tail-1 can never be mid-handshake, even if the head pops now.
  assign coalesce = st_take && (count >= MERGE_MIN_CNT) && (newest_ent.waddr == st_word);
  assign push     = st_take && !coalesce;
  assign pop      = mem_req && mem_ack;

  sb_byte_merge u_merge (
    .old_data    (newest_ent.data),
    .old_we      (newest_ent.we),
    .new_data    (st_data),
    .new_we      (st_we),
    .merged_data (merged_data),
    .merged_we   (merged_we)
  );

  // Head outputs are forced to zero while empty so stale entries never show.
  assign mem_addr  = mem_req ? AW'({head_ent.waddr, 2'b00}) : '0;
  assign mem_wdata = mem_req ? head_ent.data : '0;
  assign mem_we    = mem_req ? head_ent.we   : WE_NONE;

  // An entry slot is live when its distance from head is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    logic [PW-1:0] rel;
    assign rel         = PW'(i) - head;
    assign ent_live[i] = ({1'b0, rel} < count);
    assign ld_match[i] = ent_live[i] && (entries[i].waddr == ld_word);
  end

  // The head still counts in its ack cycle; the incoming store is never compared.
  assign ld_hazard = ld_valid && (|ld_match);

  // Queue control: pointers wrap naturally at DEPTH, count tracks occupancy; reset drops everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage: new stores land at tail, same-word stores merge into tail-1; contents are don't-care outside count.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail] <= '{waddr: st_word, data: st_data, we: st_we};
    end else if (coalesce) begin
      entries[tail_m1] <= '{waddr: newest_ent.waddr, data: merged_data, we: merged_we};
    end
  end

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Posted-write store buffer between the MEM-stage store lane aligner and the data memory write port.
- Accepts lane-aligned store words with byte write enables, queues them in order and drains them to data memory over a req/ack handshake.
- Merges consecutive stores to the same word that are still queued.
- Flags loads that hit a pending store, so the pipeline stalls the load until the buffer drains it.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- AW, 32, byte address width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  store request from MEM stage
- st_ready  out  1  buffer can accept a store this cycle
- st_addr  in  AW  store byte address; only bits [AW-1:2] are used
- st_data  in  32  lane-aligned store data
- st_we  in  4  byte write enables, one per lane
- ld_valid  in  1  load in MEM stage
- ld_addr  in  AW  load byte address; bits [AW-1:2] are compared
- ld_hazard  out  1  load word matches a pending entry
- mem_req  out  1  head entry presented to data memory
- mem_addr  out  AW  head word address as {addr[AW-1:2],2'b00}
- mem_wdata  out  32  head data
- mem_we  out  4  head byte enables
- mem_ack  in  1  memory accepts head this cycle
- sb_empty  out  1  no pending entries

Behaviour:
- Storage
  - Circular FIFO of DEPTH entries: word address, 32-bit data, 4-bit enables.
  - Head pointer, tail pointer and count, each of width clog2(DEPTH)+1 where needed.
  - Pointers wrap modulo DEPTH.
- Reset
  - count=0 and head=tail=0; all entries are invalid.
  - mem_req=0, ld_hazard=0, sb_empty=1, st_ready=1.
  - mem_addr, mem_wdata and mem_we read as 0.
  - Reset mid-operation discards pending stores without completing them. mem_req is low from the reset edge, even if mem_ack is high in that cycle.
- Acceptance
  - st_ready = (count != DEPTH). It depends only on the current count; a pop in the same cycle does not make room.
  - A store is accepted when st_valid && st_ready.
- Coalescing
  - Applies to an accepted store when count >= 2 and the tail-1 (newest) entry has the same word address.
  - The new store merges into that entry; no new entry is allocated.
  - For each lane i with st_we[i]=1: data byte i is overwritten and enable bit i is set.
  - Lanes with st_we[i]=0 keep their old value.
  - The head entry (count=1 case) is never merged, because it may be mid-handshake.
- Empty store: an accepted store with st_we=4'b0000 is dropped and has no effect on state.
- Drain handshake
  - mem_req=1 whenever count != 0.
  - mem_addr, mem_wdata and mem_we reflect the head entry and stay stable while mem_req=1 && !mem_ack.
  - mem_req && mem_ack retires the head (head+1, count-1) at the edge.
  - Zero-latency ack is permitted: a write presented in cycle N retires at the end of N if ack=1.
- Simultaneous push and pop
  - Count is unchanged; the push lands at the tail and the pop retires the head.
  - Coalescing into tail-1 with a simultaneous pop is legal when count >= 2, because tail-1 is not the head.
- Hazard
  - ld_hazard = ld_valid && (some valid entry's word address == ld_addr[AW-1:2]). Combinational.
  - The head entry counts even in the cycle it is acked (conservative).
  - The incoming st_* in the same cycle is not compared; the pipeline orders it.
- Latency: an accepted store is visible on mem_* no earlier than the next cycle.
- sb_empty = (count == 0).

Decomposition:
- Shared package (the pipeline's common definitions):
  - dmem_we_t: 4-bit enables
  - constants WE_NONE=4'b0000 and WE_WORD=4'b1111
  - store entry struct {word address, data, enables}
- Natural sub-module: sb_byte_merge. Combinational per-lane merge of (old data, old enables, new data, new enables) into (merged data, merged enables). Reused for coalescing.
- FIFO control and hazard compare remain in the top module.

Test Plan:
- Reset then one store (addr 0x100, data 0xAABBCCDD, we 4'b1111) with mem_ack held 0 -> next cycle mem_req=1, mem_addr=0x100, mem_wdata=0xAABBCCDD, mem_we=4'b1111, held stable for 3 cycles; ack in cycle 4 -> sb_empty=1 next cycle.
- Fill 4 stores to 0x0/0x4/0x8/0xC with ack=0 -> st_ready=0 after the 4th. A 5th store is held off. Ack once -> st_ready=1; drain order is 0x0, 0x4, 0x8, 0xC, then the 5th.
- Coalesce:
  - Stores 0x200 (we 0001, data 0x11), 0x300 (we 0001, data 0x22), 0x300 (we 0100, data 0x00330000) with ack=0.
  - Required: 2 entries; the second is data 0x00330022, we 4'b0101.
- Hazard: pending store at 0x304, ld_addr=0x306, ld_valid=1 -> ld_hazard=1. ld_addr=0x308 -> ld_hazard=0. ld_valid=0 -> ld_hazard=0.
- Simultaneous push/pop at full (count=4, ack=1, st_valid=1) -> st_ready=0 that cycle, head retires, count=3. Next cycle the store is accepted; pointers wrap to 0 correctly.
- Assert rst with 3 pending entries and mem_ack=1 -> no retire that edge; next cycle mem_req=0, sb_empty=1, st_ready=1. A store with we=4'b0000 leaves sb_empty=1.
